shake_128_squeeze_sampler: RTL and testbench

Consumes SHAKE128 squeeze output from the Keccak core and rejection-samples it into 23-bit polynomial coefficients uniformly below q. This is the ExpandA sampling stage. It is the output-side counterpart of the SHAKE128 input-formatting logic (rho‖j‖i plus padding), which feeds the same permutation core. It requests further squeeze blocks until 256 coefficients are accepted, then streams them to the matrix-A store over a valid/ready interface.

---
 rtl/shake_128_squeeze_sampler_if.sv | 25 ++
 rtl/shake_128_squeeze_sampler.sv | 129 ++++++++++++
 tb/tb_shake_128_squeeze_sampler.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/shake_128_squeeze_sampler_if.sv
// rtl/shake_128_squeeze_sampler_if.sv - block-in / coefficient-out handshake bundle for the ExpandA sampler

interface shake_128_squeeze_sampler_if;
    logic          start;
    logic [1599:0] state_in;
    logic          state_valid;
    logic          state_ready;
    logic          squeeze_req;
    logic [22:0]   coeff;
    logic [7:0]    coeff_idx;
    logic          coeff_valid;
    logic          coeff_ready;
    logic          busy;
    logic          done;

    modport master (
        input  start, state_in, state_valid, coeff_ready,
        output state_ready, squeeze_req, coeff, coeff_idx, coeff_valid, busy, done
    );

    modport slave (
        output start, state_in, state_valid, coeff_ready,
        input  state_ready, squeeze_req, coeff, coeff_idx, coeff_valid, busy, done
    );
endinterface

// File: rtl/shake_128_squeeze_sampler.sv
// rtl/shake_128_squeeze_sampler.sv - SHAKE128 squeeze rejection sampler (coefficients < Q); SHAKE_SAMPLER_STATS_EN adds reject_cnt

module shake_128_squeeze_sampler #(
    parameter int N_COEFF    = 256,
    parameter int Q          = 8380417,
    parameter int RATE_BYTES = 168
) (
    input  logic clk,
    input  logic rst_n,
    shake_128_squeeze_sampler_if.master bus
`ifdef SHAKE_SAMPLER_STATS_EN
    ,
    output logic [15:0] reject_cnt
`endif
);
    localparam int CHUNKS = RATE_BYTES / 3;
    localparam logic [5:0] LAST_PTR = 6'(CHUNKS - 1);
    localparam logic [7:0] LAST_CNT = 8'(N_COEFF - 1);

    typedef enum logic [1:0] {IDLE, WAIT_BLK, SCAN, EMIT} state_t;

    state_t      state, state_n;
    logic [23:0] blk [CHUNKS];
    logic [5:0]  ptr;
    logic [7:0]  cnt;
    logic [22:0] coeff_q;
    logic [7:0]  idx_q;
    logic [23:0] chunk;
    logic [22:0] cand;
    logic        cap, acc, rej, hs, sq_c, done_c;
    logic        unused_tail;

    // Chunks are stored as {b0, b1, b2}; the candidate is little-endian with b2's MSB dropped.
    assign chunk = blk[ptr];
    assign cand  = {chunk[6:0], chunk[15:8], chunk[23:16]};
    assign unused_tail = ^bus.state_in[255:0];

    always_comb begin
        state_n = state;
        cap     = 1'b0;
        acc     = 1'b0;
        rej     = 1'b0;
        hs      = 1'b0;
        sq_c    = 1'b0;
        done_c  = 1'b0;
        case (state)
            IDLE:     if (bus.start) state_n = WAIT_BLK;
            WAIT_BLK: if (bus.state_valid) begin
                cap     = 1'b1;
                state_n = SCAN;
            end
            SCAN: begin
                if (cand < 23'(Q)) begin
                    acc     = 1'b1;
                    state_n = EMIT;
                end else begin
                    rej = 1'b1;
                    if (ptr == LAST_PTR) begin
                        sq_c    = 1'b1;
                        state_n = WAIT_BLK;
                    end
                end
            end
            EMIT: if (bus.coeff_ready) begin
                hs = 1'b1;
                if (cnt == LAST_CNT) begin
                    done_c  = 1'b1;
                    state_n = IDLE;
                end else if (ptr == LAST_PTR) begin
                    sq_c    = 1'b1;
                    state_n = WAIT_BLK;
                end else begin
                    state_n = SCAN;
                end
            end
            default: state_n = IDLE;
        endcase
        // An abort pre-empts whatever the current state decided this cycle.
        if (bus.start) begin
            state_n = WAIT_BLK;
            cap     = 1'b0;
            acc     = 1'b0;
            rej     = 1'b0;
            hs      = 1'b0;
            sq_c    = 1'b0;
            done_c  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            ptr     <= '0;
            coeff_q <= '0;
            idx_q   <= '0;
            for (int i = 0; i < CHUNKS; i++) blk[i] <= '0;
        end else begin
            state <= state_n;
            if (bus.start)  cnt <= '0;
            else if (hs)    cnt <= cnt + 8'd1;
            if (cap) begin
                for (int i = 0; i < CHUNKS; i++) blk[i] <= bus.state_in[1599 - 24*i -: 24];
                ptr <= '0;
            end else if ((rej || hs) && ptr != LAST_PTR) begin
                ptr <= ptr + 6'd1;
            end
            if (acc) begin
                coeff_q <= cand;
                idx_q   <= cnt;
            end
        end
    end

`ifdef SHAKE_SAMPLER_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n || bus.start)              reject_cnt <= '0;
        else if (rej && reject_cnt != 16'hFFFF) reject_cnt <= reject_cnt + 16'd1;
    end
`endif

    assign bus.state_ready = (state == WAIT_BLK);
    assign bus.squeeze_req = sq_c;
    assign bus.coeff       = coeff_q;
    assign bus.coeff_idx   = idx_q;
    assign bus.coeff_valid = (state == EMIT);
    assign bus.busy        = (state != IDLE);
    assign bus.done        = done_c;
endmodule

// File: tb/tb_shake_128_squeeze_sampler.sv
// tb/tb_shake_128_squeeze_sampler.sv - directed bench for shake_128_squeeze_sampler

module tb_shake_128_squeeze_sampler;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    shake_128_squeeze_sampler_if bus();
`ifdef SHAKE_SAMPLER_STATS_EN
    logic [15:0] reject_cnt;
`endif

    shake_128_squeeze_sampler dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef SHAKE_SAMPLER_STATS_EN
        ,
        .reject_cnt (reject_cnt)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    logic [22:0] q_coeff[$];
    logic [7:0]  q_idx[$];
    int          q_cyc[$];
    int n_sq, n_done, done_hs, cap_cyc, vld_cyc, sq_cyc, n_vld;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.coeff_valid && bus.coeff_ready) begin
                q_coeff.push_back(bus.coeff);
                q_idx.push_back(bus.coeff_idx);
                q_cyc.push_back(cyc);
            end
            if (bus.squeeze_req) begin
                n_sq++;
                if (sq_cyc < 0) sq_cyc = cyc;
            end
            if (bus.done) begin
                n_done++;
                done_hs = q_coeff.size();
            end
            if (bus.state_valid && bus.state_ready && cap_cyc < 0) cap_cyc = cyc;
            if (bus.coeff_valid && vld_cyc < 0) vld_cyc = cyc;
            if (bus.coeff_valid) n_vld++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        q_coeff.delete();
        q_idx.delete();
        q_cyc.delete();
        n_sq = 0; n_done = 0; done_hs = -1;
        cap_cyc = -1; vld_cyc = -1; sq_cyc = -1; n_vld = 0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        clear_mon();
    endtask

    task automatic wait_q(input int n, input int budget);
        int i = 0;
        while (q_coeff.size() < n && i < budget) begin
            @(posedge clk); #1;
            i++;
        end
        check("wait_coeffs", 32'(q_coeff.size() >= n), 32'd1);
    endtask

    function automatic logic [1599:0] blk_fill(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        logic [1599:0] b = '0;
        for (int k = 0; k < 56; k++) b[1599 - 24*k -: 24] = {b0, b1, b2};
        return b;
    endfunction

    initial begin
        logic [1599:0] b;
        int bad;
        int i;

        bus.start = 1'b0;
        bus.state_in = '0;
        bus.state_valid = 1'b0;
        bus.coeff_ready = 1'b0;
        clear_mon();
        repeat (3) @(posedge clk);
        #1;
        check("rst_coeff_valid", 32'(bus.coeff_valid), 32'd0);
        check("rst_coeff",       32'(bus.coeff),       32'd0);
        check("rst_busy",        32'(bus.busy),        32'd0);
        check("rst_state_ready", 32'(bus.state_ready), 32'd0);
        check("rst_squeeze_req", 32'(bus.squeeze_req), 32'd0);
`ifdef SHAKE_SAMPLER_STATS_EN
        check("rst_reject_cnt",  32'(reject_cnt),      32'd0);
`endif
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Full polynomial from all-ones blocks: 4 x 56 + 32 coefficients.
        bus.state_in = blk_fill(8'h01, 8'h00, 8'h00);
        bus.state_valid = 1'b1;
        bus.coeff_ready = 1'b1;
        pulse_start();
        i = 0;
        while (n_done == 0 && i < 2000) begin
            @(posedge clk); #1;
            i++;
        end
        check("a_done_count", 32'(n_done), 32'd1);
        check("a_done_at_hs", 32'(done_hs), 32'd256);
        check("a_num_coeffs", 32'(q_coeff.size()), 32'd256);
        check("a_squeeze_cnt", 32'(n_sq), 32'd4);
        check("a_busy_after", 32'(bus.busy), 32'd0);
        check("a_first_latency", 32'(vld_cyc - cap_cyc), 32'd2);
        if (q_cyc.size() >= 2) check("a_steady_rate", 32'(q_cyc[1] - q_cyc[0]), 32'd2);
        else check("a_steady_rate", 32'(q_cyc.size()), 32'd2);
        bad = 0;
        foreach (q_coeff[k]) if (q_coeff[k] !== 23'd1 || q_idx[k] !== 8'(k)) bad++;
        check("a_values_idx", 32'(bad), 32'd0);

        // Boundary chunks: Q rejected, FFFFFF rejected, Q-1 accepted, b2 MSB masked.
        b = blk_fill(8'hFF, 8'hFF, 8'hFF);
        b[1599 -: 24]      = {8'h01, 8'hE0, 8'h7F};
        b[1599 - 48 -: 24] = {8'h00, 8'hE0, 8'h7F};
        b[1599 - 72 -: 24] = {8'h05, 8'h00, 8'h80};
        bus.state_in = b;
        pulse_start();
        wait_q(1, 100);
        check("b_latency_2rej", 32'(vld_cyc - cap_cyc), 32'd4);
`ifdef SHAKE_SAMPLER_STATS_EN
        check("b_reject_cnt", 32'(reject_cnt), 32'd2);
`endif
        wait_q(2, 100);
        if (q_coeff.size() >= 2) begin
            check("b_coeff_qm1", 32'(q_coeff[0]), 32'd8380416);
            check("b_idx0",      32'(q_idx[0]),   32'd0);
            check("b_coeff_msb", 32'(q_coeff[1]), 32'd5);
            check("b_idx1",      32'(q_idx[1]),   32'd1);
        end

        // All-FF block: 56 rejects, then squeeze_req, never coeff_valid.
        bus.state_in = blk_fill(8'hFF, 8'hFF, 8'hFF);
        pulse_start();
        i = 0;
        while (n_sq == 0 && i < 200) begin
            @(posedge clk); #1;
            i++;
        end
        check("c_squeeze_seen", 32'(n_sq), 32'd1);
        check("c_reject_cycles", 32'(sq_cyc - cap_cyc), 32'd56);
        check("c_no_valid", 32'(n_vld), 32'd0);
        check("c_state_ready", 32'(bus.state_ready), 32'd1);
`ifdef SHAKE_SAMPLER_STATS_EN
        check("c_reject_cnt", 32'(reject_cnt), 32'd56);
`endif

        // Backpressure: chunk k carries value k+1 so the coefficient exposes ptr.
        b = '0;
        for (int k = 0; k < 56; k++) b[1599 - 24*k -: 24] = {8'(k + 1), 8'h00, 8'h00};
        bus.state_in = b;
        bus.coeff_ready = 1'b0;
        pulse_start();
        i = 0;
        while (!bus.coeff_valid && i < 50) begin
            @(posedge clk); #1;
            i++;
        end
        check("d_valid_seen", 32'(bus.coeff_valid), 32'd1);
        bad = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (bus.coeff_valid !== 1'b1 || bus.coeff !== 23'd1 || bus.coeff_idx !== 8'd0) bad++;
        end
        check("d_hold_stable", 32'(bad), 32'd0);
        bus.coeff_ready = 1'b1;
        wait_q(2, 50);
        if (q_coeff.size() >= 2) begin
            check("d_first_coeff", 32'(q_coeff[0]), 32'd1);
            check("d_ptr_frozen", 32'(q_coeff[1]), 32'd2);
            check("d_idx1", 32'(q_idx[1]), 32'd1);
            check("d_release_gap", 32'(q_cyc[1] - q_cyc[0]), 32'd2);
        end

        // Abort mid-EMIT at cnt=100.
        bus.state_in = blk_fill(8'h01, 8'h00, 8'h00);
        pulse_start();
        i = 0;
        while (!(bus.coeff_valid && bus.coeff_idx == 8'd100) && i < 1000) begin
            @(posedge clk); #1;
            i++;
        end
        check("e_reached_100", 32'(bus.coeff_idx), 32'd100);
        bus.start = 1'b1;
        bus.coeff_ready = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("e_valid_dropped", 32'(bus.coeff_valid), 32'd0);
        check("e_wait_blk", 32'(bus.state_ready), 32'd1);
        check("e_no_done", 32'(n_done), 32'd0);
        clear_mon();
        bus.coeff_ready = 1'b1;
        wait_q(1, 50);
        if (q_idx.size() >= 1) check("e_idx_restart", 32'(q_idx[0]), 32'd0);

        // Reset while scanning an all-FF block.
        bus.state_in = blk_fill(8'hFF, 8'hFF, 8'hFF);
        pulse_start();
        @(posedge clk); #1;
        check("f_in_scan", 32'({bus.busy, bus.state_ready, bus.coeff_valid}), 32'b100);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("f_rst_outputs", 32'({bus.busy, bus.state_ready, bus.coeff_valid, bus.squeeze_req, bus.done}), 32'd0);
        check("f_rst_coeff", 32'(bus.coeff), 32'd0);
        check("f_rst_idx", 32'(bus.coeff_idx), 32'd0);
`ifdef SHAKE_SAMPLER_STATS_EN
        check("f_rst_reject_cnt", 32'(reject_cnt), 32'd0);
`endif
        rst_n = 1'b1;
        @(posedge clk); #1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
